// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH
// cycles, LSB first, with a registered carry and start/done handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request, sampled only while idle
//   sub      0 = a+b, 1 = a-b, sampled with start
//   a, b     WIDTH-bit operands, sampled with start
//   busy     high while an operation is running or finishing
//   done     one-cycle pulse when sum/cout/overflow update
//   sum      WIDTH-bit result (two's complement for subtract)
//   cout     carry out of the MSB (subtract: 1 = no borrow)
//   overflow signed overflow
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nx;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic bit_s;
  logic bit_c;
  logic last;
  logic c_msb;

  // One full-adder cell applied to the current LSBs.
  assign bit_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_c = (a_sr[0] & b_sr[0])
               | (a_sr[0] & carry)
               | (b_sr[0] & carry);

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // On the last bit the registered carry is the carry into the MSB.
  assign c_msb = carry;

  assign r_nx = {bit_s, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // Subtract as a + ~b + 1: invert b, seed carry with 1.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          r_sr  <= r_nx;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum      <= r_nx;
            cout     <= bit_c;
            overflow <= c_msb ^ bit_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8 vectors plus an
// exhaustive WIDTH=4 sweep with start held high.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic       sub8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;
  logic       ov8;

  logic       start4 = 1'b0;
  logic       sub4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;
  logic       ov4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] prev8 = '0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .overflow(ov8)
  );

  serial_addsub #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4),
    .a(a4), .b(b4), .busy(busy4), .done(done4),
    .sum(sum4), .cout(cout4), .overflow(ov4)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op8(input logic [7:0] a,
                           input logic [7:0] b,
                           input logic s);
    a8 = a;
    b8 = b;
    sub8 = s;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Called in the first cycle after acceptance (n0 = cycles already
  // spent in the operation, all of which are assumed busy).
  task automatic finish_op8(input string tag,
                            input int n0,
                            input logic [7:0] es,
                            input logic ec,
                            input logic eo);
    int n;
    int bc;
    n = n0;
    bc = n0;
    while (!done8 && n < 30) begin
      if (busy8) bc++;
      check({tag, "_hold"}, {24'd0, sum8}, {24'd0, prev8});
      tick();
      n++;
    end
    if (busy8) bc++;
    check({tag, "_lat"}, n, 8);
    check({tag, "_done"}, {31'd0, done8}, 1);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
    check({tag, "_ov"}, {31'd0, ov8}, {31'd0, eo});
    check({tag, "_busycyc"}, bc, 9);
    tick();
    check({tag, "_busy_end"}, {31'd0, busy8}, 0);
    check({tag, "_done_end"}, {31'd0, done8}, 0);
    check({tag, "_sum_keep"}, {24'd0, sum8}, {24'd0, es});
    prev8 = es;
  endtask

  task automatic run_op8(input string tag,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input logic s,
                         input logic [7:0] es,
                         input logic ec,
                         input logic eo);
    start_op8(a, b, s);
    finish_op8(tag, 0, es, ec, eo);
  endtask

  task automatic set_op4(input int i);
    logic [8:0] v;
    v = 9'(i);
    a4 = v[3:0];
    b4 = v[7:4];
    sub4 = v[8];
  endtask

  initial begin
    int n;
    int dp;
    int last_done;
    logic [8:0] v;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [4:0] full;
    logic [3:0] low;
    logic       es;

    tick();
    tick();
    check("rst_busy", {31'd0, busy8}, 0);
    check("rst_done", {31'd0, done8}, 0);
    check("rst_sum", {24'd0, sum8}, 0);
    check("rst_cout", {31'd0, cout8}, 0);
    check("rst_ov", {31'd0, ov8}, 0);
    rst = 1'b0;
    tick();

    run_op8("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op8("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Re-pulse start in RUN cycle 3 with other operands.
    start_op8(8'h11, 8'h22, 1'b0);
    tick();
    tick();
    a8 = 8'hAA;
    b8 = 8'h55;
    sub8 = 1'b1;
    start8 = 1'b1;
    check("repulse_busy", {31'd0, busy8}, 1);
    tick();
    start8 = 1'b0;
    finish_op8("repulse", 3, 8'h33, 1'b0, 1'b0);

    // Reset at RUN cycle 4.
    start_op8(8'h12, 8'h34, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy8}, 0);
    check("abort_sum", {24'd0, sum8}, 0);
    check("abort_done", {31'd0, done8}, 0);
    dp = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dp++;
      tick();
    end
    check("abort_no_done", dp, 0);
    prev8 = 8'h00;
    run_op8("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep, start held high throughout.
    set_op4(0);
    start4 = 1'b1;
    n = 0;
    while (!busy4 && n < 5) begin
      tick();
      n++;
    end
    check("w4_accept", {31'd0, busy4}, 1);
    last_done = 0;
    for (int i = 0; i < 512; i++) begin
      if (i < 511) set_op4(i + 1);
      else start4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
        tick();
        n++;
      end
      v = 9'(i);
      ea = v[3:0];
      eb = v[8] ? ~v[7:4] : v[7:4];
      full = {1'b0, ea} + {1'b0, eb} + {4'd0, v[8]};
      low = {1'b0, ea[2:0]} + {1'b0, eb[2:0]} + {3'd0, v[8]};
      es = low[3];
      check("w4_done", {31'd0, done4}, 1);
      check("w4_sum", {28'd0, sum4}, {28'd0, full[3:0]});
      check("w4_cout", {31'd0, cout4}, {31'd0, full[4]});
      check("w4_ov", {31'd0, ov4}, {31'd0, es ^ full[4]});
      if (i > 0) check("w4_spacing", cyc - last_done, 6);
      last_done = cyc;
      tick();
      tick();
    end
    check("w4_idle_end", {31'd0, busy4}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
